// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: MIPS opcode/funct encodings,
// ALU operation codes and the ID/EX control bundle.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_e alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } rtype_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

    // Maps an R-type funct field to its ALU operation; legal=0 for anything unsupported.
    function automatic rtype_t rtype_decode(input logic [5:0] funct);
        rtype_t r;
        r.legal = 1'b1;
        r.op    = ALU_ADD;
        case (funct)
            FUNCT_ADD: r.op = ALU_ADD;
            FUNCT_SUB: r.op = ALU_SUB;
            FUNCT_AND: r.op = ALU_AND;
            FUNCT_OR:  r.op = ALU_OR;
            FUNCT_SLT: r.op = ALU_SLT;
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_if.sv
// Bundle between fetch/writeback and the decode stage. The master side
// supplies instruction words and writeback; the slave (id_stage) returns the
// branch/jump strobes and the registered ID/EX contents.
interface id_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [31:0]       instr_if;
    logic [31:0]       instr_id;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              branch;
    logic              jump;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_alu_src;
    logic [2:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [ADDR_W-1:0] ex_dst;
    logic              ill_instr;

    modport master (
        output instr_if, instr_id, wb_we, wb_addr, wb_data,
        input  branch, jump, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_dst, ill_instr
    );

    modport slave (
        input  instr_if, instr_id, wb_we, wb_addr, wb_data,
        output branch, jump, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_dst, ill_instr
    );
endinterface

// File: rtl/id_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0
// hard-wired to zero, async active-low reset clearing every entry.
// Optional macro ID_WB_BYPASS_EN makes a same-cycle writeback visible on the
// read ports (write-through); without it reads see only the stored value.
module id_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wb_hit;

    assign wb_hit = wb_we && (wb_addr != '0);

    // Storage update; $0 is never written so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read port rs, optionally forwarding the writeback value, $0 forced to zero.
    always_comb begin
        rs_data = regs[rs_addr];
`ifdef ID_WB_BYPASS_EN
        if (wb_hit && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end
`endif
        if (rs_addr == '0) begin
            rs_data = '0;
        end
    end

    // Read port rt, same rules as rs.
    always_comb begin
        rt_data = regs[rt_addr];
`ifdef ID_WB_BYPASS_EN
        if (wb_hit && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end
`endif
        if (rt_addr == '0) begin
            rt_data = '0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: decodes instr_id,
// reads the register file, resolves beq/bne in this cycle, flags j in the
// fetch word, and registers the result into ID/EX. Unsupported encodings
// load a bubble and set a sticky ill_instr flag.
// Optional macro ID_WB_BYPASS_EN (see id_regfile) enables writeback-to-decode
// forwarding.
module id_stage
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic clk,
    input logic reset,
    id_if.slave bus
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;

    ex_ctrl_t          ctrl_d;
    ex_ctrl_t          ctrl_q;
    rtype_t            rtype;
    logic [ADDR_W-1:0] dst_d;
    logic [ADDR_W-1:0] dst_q;
    logic              illegal;
    logic              is_beq;
    logic              is_bne;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] imm_q;
    logic              ill_q;

    assign opcode  = bus.instr_id[31:26];
    assign funct   = bus.instr_id[5:0];
    assign rs_addr = bus.instr_id[21 +: ADDR_W];
    assign rt_addr = bus.instr_id[16 +: ADDR_W];
    assign rd_addr = bus.instr_id[11 +: ADDR_W];
    assign imm_ext = {{(DATA_W-16){bus.instr_id[15]}}, bus.instr_id[15:0]};
    assign rtype   = rtype_decode(funct);

    id_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wb_we   (bus.wb_we),
        .wb_addr (bus.wb_addr),
        .wb_data (bus.wb_data)
    );

    // Control decode; anything that does no EX work (nop, branches, jump, illegal) stays a bubble.
    always_comb begin
        ctrl_d  = CTRL_BUBBLE;
        dst_d   = '0;
        illegal = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        if (bus.instr_id != '0) begin
            case (opcode)
                OP_RTYPE: begin
                    if (rtype.legal) begin
                        ctrl_d.valid     = 1'b1;
                        ctrl_d.reg_write = 1'b1;
                        ctrl_d.alu_op    = rtype.op;
                        dst_d            = rd_addr;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_ADDI: begin
                    ctrl_d.valid     = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    dst_d            = rt_addr;
                end
                OP_LW: begin
                    ctrl_d.valid     = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.mem_read  = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    dst_d            = rt_addr;
                end
                OP_SW: begin
                    ctrl_d.valid     = 1'b1;
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                end
                OP_BEQ:  is_beq = 1'b1;
                OP_BNE:  is_bne = 1'b1;
                OP_J:    ;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign bus.branch = (is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data));
    assign bus.jump   = (bus.instr_if[31:26] == OP_J);

    // ID/EX pipeline register and sticky illegal flag; bubbles carry zero data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= CTRL_BUBBLE;
            dst_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
            ill_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            dst_q  <= dst_d;
            rs_q   <= ctrl_d.valid ? rs_data : '0;
            rt_q   <= ctrl_d.valid ? rt_data : '0;
            imm_q  <= ctrl_d.valid ? imm_ext : '0;
            ill_q  <= ill_q | illegal;
        end
    end

    assign bus.ex_valid     = ctrl_q.valid;
    assign bus.ex_reg_write = ctrl_q.reg_write;
    assign bus.ex_mem_read  = ctrl_q.mem_read;
    assign bus.ex_mem_write = ctrl_q.mem_write;
    assign bus.ex_alu_src   = ctrl_q.alu_src;
    assign bus.ex_alu_op    = ctrl_q.alu_op;
    assign bus.ex_rs_data   = rs_q;
    assign bus.ex_rt_data   = rt_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_dst       = dst_q;
    assign bus.ill_instr    = ill_q;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: a directed vector table, hand-written reset
// sequences, and a randomized run against a mnemonic-level reference model.
module tb_id_stage;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    id_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v, rw, mr, mw, src;
        logic [2:0]  op;
        logic [31:0] rs, rt, imm;
        logic [4:0]  dst;
        logic        br, jmp, ill;
    } exp_t;

    typedef struct {
        logic [31:0] iif, iid;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        exp_t        e;
    } vec_t;

    logic [31:0] mregs [32];
    logic        mill;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] iif, input logic [31:0] iid, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        bus.instr_if = iif;
        bus.instr_id = iid;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        #1;
    endtask

    task automatic checkComb(input string tag, input exp_t e);
        checkOutput({tag, ".branch"}, 32'(bus.branch), 32'(e.br));
        checkOutput({tag, ".jump"},   32'(bus.jump),   32'(e.jmp));
    endtask

    task automatic checkEx(input string tag, input exp_t e);
        checkOutput({tag, ".ex_valid"},     32'(bus.ex_valid),     32'(e.v));
        checkOutput({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
        checkOutput({tag, ".ex_mem_read"},  32'(bus.ex_mem_read),  32'(e.mr));
        checkOutput({tag, ".ex_mem_write"}, 32'(bus.ex_mem_write), 32'(e.mw));
        checkOutput({tag, ".ex_alu_src"},   32'(bus.ex_alu_src),   32'(e.src));
        checkOutput({tag, ".ex_alu_op"},    32'(bus.ex_alu_op),    32'(e.op));
        checkOutput({tag, ".ex_dst"},       32'(bus.ex_dst),       32'(e.dst));
        checkOutput({tag, ".ill_instr"},    32'(bus.ill_instr),    32'(e.ill));
        if (e.v) begin
            checkOutput({tag, ".ex_rs_data"}, bus.ex_rs_data, e.rs);
            checkOutput({tag, ".ex_rt_data"}, bus.ex_rt_data, e.rt);
            checkOutput({tag, ".ex_imm"},     bus.ex_imm,     e.imm);
        end
    endtask

    function automatic exp_t mk(input logic v, rw, mr, mw, src, input logic [2:0] op,
                                input logic [31:0] rs, rt, imm, input logic [4:0] dst,
                                input logic br, jmp, ill);
        exp_t e;
        e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.src = src; e.op = op;
        e.rs = rs; e.rt = rt; e.imm = imm; e.dst = dst;
        e.br = br; e.jmp = jmp; e.ill = ill;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [31:0] iif, iid, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input exp_t e);
        vec_t t;
        t.iif = iif; t.iid = iid; t.we = we; t.wa = wa; t.wd = wd; t.e = e;
        return t;
    endfunction

    // Reference model: name the instruction first, then derive behaviour from the name.
    function automatic string mnem(input logic [31:0] w);
        int op = int'(w >> 26);
        int fn = int'(w & 32'h3F);
        if (w == 32'd0) return "nop";
        if (op == 0) begin
            if (fn == 32) return "add";
            if (fn == 34) return "sub";
            if (fn == 36) return "and";
            if (fn == 37) return "or";
            if (fn == 42) return "slt";
            return "illegal";
        end
        if (op == 8)  return "addi";
        if (op == 35) return "lw";
        if (op == 43) return "sw";
        if (op == 4)  return "beq";
        if (op == 5)  return "bne";
        if (op == 2)  return "j";
        return "illegal";
    endfunction

    function automatic logic [31:0] mread(input int r, input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (BYPASS && we && int'(wa) == r) return wd;
        return mregs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] iif, iid, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        string       m   = mnem(iid);
        int          rsn = int'((iid >> 21) & 32'd31);
        int          rtn = int'((iid >> 16) & 32'd31);
        int          rdn = int'((iid >> 11) & 32'd31);
        logic [31:0] rv  = mread(rsn, we, wa, wd);
        logic [31:0] tv  = mread(rtn, we, wa, wd);
        logic [31:0] sx  = iid[15] ? ((iid & 32'hFFFF) | 32'hFFFF_0000) : (iid & 32'hFFFF);
        e = mk(0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0);
        e.jmp = ((iif >> 26) == 32'd2);
        if (m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt") begin
            e.v = 1; e.rw = 1; e.dst = 5'(rdn);
            e.op = (m == "add") ? 3'd0 : (m == "sub") ? 3'd1 : (m == "and") ? 3'd2 :
                   (m == "or")  ? 3'd3 : 3'd4;
        end else if (m == "addi" || m == "lw") begin
            e.v = 1; e.rw = 1; e.src = 1; e.dst = 5'(rtn); e.mr = (m == "lw");
        end else if (m == "sw") begin
            e.v = 1; e.mw = 1; e.src = 1;
        end else if (m == "beq") begin
            e.br = (rv == tv);
        end else if (m == "bne") begin
            e.br = (rv != tv);
        end
        e.rs  = rv;
        e.rt  = tv;
        e.imm = sx;
        e.ill = mill || (m == "illegal");
        return e;
    endfunction

    vec_t tbl [20];

    initial begin
        exp_t  e;
        exp_t  z;
        string m;
        logic [31:0] iid, iif;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;

        z = mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 0, 0, 0);

        // Directed table; register state accumulates from one entry to the next.
        tbl[0]  = mkv(0, 32'h2209_0190, 1, 5'd17, 32'd5,   mk(1,1,0,0,1,3'd0, 0, 0, 32'd400, 5'd9, 0,0,0));
        tbl[1]  = mkv(0, 32'h0000_0000, 1, 5'd18, 32'd7,   z);
        // add $s2,$s2,$s1 encodes as 0x0251_9020
        tbl[2]  = mkv(0, 32'h0251_9020, 1, 5'd9,  32'd400, mk(1,1,0,0,0,3'd0, 7, 5, 32'hFFFF_9020, 5'd18, 0,0,0));
        tbl[3]  = mkv(0, 32'h1609_FFFC, 0, 5'd0,  32'd0,   mk(0,0,0,0,0,3'd0, 0, 0, 0, 5'd0, 1,0,0));
        tbl[4]  = mkv(0, 32'h0000_0000, 1, 5'd9,  32'd0,   z);
        tbl[5]  = mkv(32'h0800_0004, 32'h1609_FFFC, 0, 5'd0, 0, mk(0,0,0,0,0,3'd0, 0,0,0, 5'd0, 0,1,0));
        tbl[6]  = mkv(32'h0800_0004, 32'h1210_0003, 0, 5'd0, 0, mk(0,0,0,0,0,3'd0, 0,0,0, 5'd0, 1,1,0));
        tbl[7]  = mkv(0, 32'h0000_0000, 1, 5'd0,  32'hFFFF_FFFF, z);
        tbl[8]  = mkv(0, 32'h0012_4020, 1, 5'd0,  32'hFFFF_FFFF, mk(1,1,0,0,0,3'd0, 0, 7, 32'h4020, 5'd8, 0,0,0));
        tbl[9]  = mkv(0, 32'h8E2A_0008, 0, 5'd0,  0, mk(1,1,1,0,1,3'd0, 5, 0, 32'd8, 5'd10, 0,0,0));
        tbl[10] = mkv(0, 32'hAE32_FFFC, 0, 5'd0,  0, mk(1,0,0,1,1,3'd0, 5, 7, 32'hFFFF_FFFC, 5'd0, 0,0,0));
        tbl[11] = mkv(0, 32'h0232_1822, 0, 5'd0,  0, mk(1,1,0,0,0,3'd1, 5, 7, 32'h1822, 5'd3, 0,0,0));
        tbl[12] = mkv(0, 32'h0232_2024, 0, 5'd0,  0, mk(1,1,0,0,0,3'd2, 5, 7, 32'h2024, 5'd4, 0,0,0));
        tbl[13] = mkv(0, 32'h0232_2825, 0, 5'd0,  0, mk(1,1,0,0,0,3'd3, 5, 7, 32'h2825, 5'd5, 0,0,0));
        tbl[14] = mkv(0, 32'h0232_302A, 0, 5'd0,  0, mk(1,1,0,0,0,3'd4, 5, 7, 32'h302A, 5'd6, 0,0,0));
        tbl[15] = mkv(0, 32'h2121_0010, 1, 5'd9,  32'd8, mk(1,1,0,0,1,3'd0, BYPASS ? 32'd8 : 32'd0, 0, 32'd16, 5'd1, 0,0,0));
        tbl[16] = mkv(0, 32'h2121_0010, 0, 5'd0,  0, mk(1,1,0,0,1,3'd0, 8, 0, 32'd16, 5'd1, 0,0,0));
        tbl[17] = mkv(0, 32'hFC00_0000, 0, 5'd0,  0, mk(0,0,0,0,0,3'd0, 0,0,0, 5'd0, 0,0,1));
        tbl[18] = mkv(0, 32'h0232_1822, 0, 5'd0,  0, mk(1,1,0,0,0,3'd1, 5, 7, 32'h1822, 5'd3, 0,0,1));
        tbl[19] = mkv(0, 32'h0000_0001, 0, 5'd0,  0, mk(0,0,0,0,0,3'd0, 0,0,0, 5'd0, 0,0,1));

        // Power-on reset with quiet inputs.
        reset        = 1'b0;
        bus.instr_if = '0;
        bus.instr_id = '0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkEx("reset", z);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].iif, tbl[i].iid, tbl[i].we, tbl[i].wa, tbl[i].wd);
            checkComb($sformatf("vec%0d", i), tbl[i].e);
            @(posedge clk);
            #1;
            checkEx($sformatf("vec%0d", i), tbl[i].e);
        end

        // Reset asserted mid-cycle clears ID/EX and the sticky flag immediately.
        applyStimulus(0, 32'h0232_1822, 0, 5'd0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkEx("midreset", z);
        checkOutput("midreset.ex_rs_data", bus.ex_rs_data, 32'd0);
        checkOutput("midreset.ex_imm",     bus.ex_imm,     32'd0);
        @(posedge clk);
        #1;
        checkEx("heldreset", z);
        @(negedge clk);
        reset = 1'b1;

        // Register file was cleared: sub $3,$17,$18 now reads zeros.
        applyStimulus(0, 32'h0232_1822, 0, 5'd0, 0);
        @(posedge clk);
        #1;
        checkEx("postreset", mk(1,1,0,0,0,3'd1, 0, 0, 32'h1822, 5'd3, 0,0,0));

        // Randomized run against the reference model, starting from a cleared state.
        for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
        mill = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a = 5'($urandom_range(0, 7));
            logic [4:0] b = 5'($urandom_range(0, 7));
            logic [4:0] d = 5'($urandom_range(0, 7));
            logic [15:0] imm = 16'($urandom);
            int k = $urandom_range(0, 11);
            case (k)
                0:  iid = {6'd0, a, b, d, 5'd0, 6'd32};
                1:  iid = {6'd0, a, b, d, 5'd0, 6'd34};
                2:  iid = {6'd0, a, b, d, 5'd0, 6'd36};
                3:  iid = {6'd0, a, b, d, 5'd0, 6'd37};
                4:  iid = {6'd0, a, b, d, 5'd0, 6'd42};
                5:  iid = {6'd8,  a, b, imm};
                6:  iid = {6'd35, a, b, imm};
                7:  iid = {6'd43, a, b, imm};
                8:  iid = {6'd4,  a, b, imm};
                9:  iid = {6'd5,  a, b, imm};
                10: iid = {6'd2, 26'($urandom)};
                default: iid = 32'd0;
            endcase
            if (i == 300) iid = {6'b111111, 26'($urandom)};
            iif = $urandom;
            if ($urandom_range(0, 3) == 0) iif[31:26] = 6'd2;
            else if (iif[31:26] == 6'd2) iif[31:26] = 6'd3;
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 7));
            wd = 32'($urandom_range(0, 3));

            applyStimulus(iif, iid, we, wa, wd);
            e = model(iif, iid, we, wa, wd);
            m = mnem(iid);
            checkComb($sformatf("rnd%0d_%s", i, m), e);
            mill = e.ill;
            if (we && wa != 5'd0) mregs[wa] = wd;
            @(posedge clk);
            #1;
            checkEx($sformatf("rnd%0d_%s", i, m), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
